cordic_vectoring: RTL and testbench



---
 rtl/cordic_vectoring_if.sv | 23 ++
 rtl/cordic_vectoring.sv | 119 +++++++++++
 tb/tb_cordic_vectoring.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cordic_vectoring_if.sv
// rtl/cordic_vectoring_if.sv - sample/result handshake bundle for the vectoring CORDIC
interface cordic_vectoring_if #(
   parameter int SZ = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic signed [SZ-1:0] x_in;
   logic signed [SZ-1:0] y_in;
   logic                 out_valid;
   logic                 out_ready;
   logic [SZ:0]          mag;
   logic [31:0]          angle_out;

   modport master (
      output in_valid, x_in, y_in, out_ready,
      input  in_ready, out_valid, mag, angle_out
   );

   modport slave (
      input  in_valid, x_in, y_in, out_ready,
      output in_ready, out_valid, mag, angle_out
   );
endinterface

// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative vectoring CORDIC: (X,Y) to scaled magnitude and atan2 phase
module cordic_vectoring #(
   parameter int SZ   = 16,
   parameter int ITER = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   cordic_vectoring_if.slave bus
);
   localparam int         XW   = SZ + 3;
   localparam logic [4:0] LAST = 5'(ITER - 1);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

   state_t               state, state_nx;
   logic signed [XW-1:0] x, y;
   logic signed [XW-1:0] xe, ye, xs, ys;
   logic [31:0]          z;
   logic [4:0]           i;
   logic                 zero;
   logic                 unused_xmsb;

   function automatic logic [31:0] atan_tab(input logic [4:0] k);
      case (k)
         5'd0:  atan_tab = 32'h2000_0000;
         5'd1:  atan_tab = 32'h12E4_051E;
         5'd2:  atan_tab = 32'h09FB_385B;
         5'd3:  atan_tab = 32'h0511_11D4;
         5'd4:  atan_tab = 32'h028B_0D43;
         5'd5:  atan_tab = 32'h0145_D7E1;
         5'd6:  atan_tab = 32'h00A2_F61E;
         5'd7:  atan_tab = 32'h0051_7C55;
         5'd8:  atan_tab = 32'h0028_BE53;
         5'd9:  atan_tab = 32'h0014_5F2F;
         5'd10: atan_tab = 32'h000A_2F98;
         5'd11: atan_tab = 32'h0005_17CC;
         5'd12: atan_tab = 32'h0002_8BE6;
         5'd13: atan_tab = 32'h0001_45F3;
         5'd14: atan_tab = 32'h0000_A2FA;
         5'd15: atan_tab = 32'h0000_517D;
         5'd16: atan_tab = 32'h0000_28BE;
         5'd17: atan_tab = 32'h0000_145F;
         5'd18: atan_tab = 32'h0000_0A30;
         5'd19: atan_tab = 32'h0000_0518;
         5'd20: atan_tab = 32'h0000_028C;
         5'd21: atan_tab = 32'h0000_0146;
         5'd22: atan_tab = 32'h0000_00A3;
         5'd23: atan_tab = 32'h0000_0051;
         default: atan_tab = 32'h0000_0000;
      endcase
   endfunction

   // Three guard bits let -2^(SZ-1) negate and the K*sqrt(2) growth fit.
   assign xe = {{3{bus.x_in[SZ-1]}}, bus.x_in};
   assign ye = {{3{bus.y_in[SZ-1]}}, bus.y_in};
   assign xs = x >>> i;
   assign ys = y >>> i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (bus.in_valid)  state_nx = S_ITER;
         S_ITER:  if (i == LAST)     state_nx = S_DONE;
         S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x    <= '0;
         y    <= '0;
         z    <= '0;
         i    <= '0;
         zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (bus.in_valid) begin
               // Left half-plane is folded into the right one by a 180 degree pre-rotation.
               if (bus.x_in[SZ-1]) begin
                  x <= -xe;
                  y <= -ye;
                  z <= 32'h8000_0000;
               end else begin
                  x <= xe;
                  y <= ye;
                  z <= 32'h0000_0000;
               end
               zero <= (bus.x_in == '0) && (bus.y_in == '0);
               i    <= '0;
            end
            S_ITER: begin
               if (!y[XW-1]) begin
                  x <= x + ys;
                  y <= y - xs;
                  z <= z + atan_tab(i);
               end else begin
                  x <= x - ys;
                  y <= y + xs;
                  z <= z - atan_tab(i);
               end
               i <= i + 5'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.mag       = zero ? '0 : x[SZ:0];
   assign bus.angle_out = zero ? 32'h0 : z;
   assign unused_xmsb   = ^x[XW-1:SZ+1];
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb/tb_cordic_vectoring.sv - scoreboard bench for cordic_vectoring
module tb_cordic_vectoring;
   localparam int  SZ     = 16;
   localparam int  ITER   = 16;
   localparam real K      = 1.6468;
   localparam real TWO_PI = 6.283185307179586;
   localparam real CNT    = 4294967296.0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cordic_vectoring_if #(.SZ(SZ)) bus();
   cordic_vectoring #(.SZ(SZ), .ITER(ITER)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {int x; int y;} smp_t;
   smp_t sb[$];

   int n_cmp    = 0;
   int n_bad    = 0;
   int cyc      = 0;
   int last_acc = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_bad++;
         $error("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic chk_tol(input string tag, input logic [63:0] got, input longint want,
                          input longint tol, input bit wrap);
      longint d;
      bit     ok;
      if (wrap) d = longint'($signed(got[31:0] - want[31:0]));
      else      d = longint'(got) - want;
      if (d < 0) d = -d;
      ok = !$isunknown(got) && (d <= tol);
      n_cmp++;
      assert (ok === 1'b1) else begin
         n_bad++;
         $error("FAIL %s: got %0d expected %0d tol %0d", tag, got, want, tol);
      end
   endtask

   function automatic longint exp_ang(input int xv, input int yv);
      real    a;
      longint c;
      a = $atan2(real'(yv), real'(xv));
      if (a < 0.0) a = a + TWO_PI;
      c = longint'(a / TWO_PI * CNT);
      return c & 64'h0000_0000_FFFF_FFFF;
   endfunction

   task automatic send(input int xv, input int yv, input bit push, input bit hold);
      int n;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      chk_eq("ready_before_send", bus.in_ready, 1);
      bus.x_in     = 16'(xv);
      bus.y_in     = 16'(yv);
      bus.in_valid = 1'b1;
      tick();
      last_acc = cyc;
      if (push) sb.push_back('{xv, yv});
      if (hold) begin
         bus.x_in = 16'h7ABC;
         bus.y_in = 16'h1234;
      end else begin
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic result(input int hold);
      int          lat;
      bit          rdy_low;
      bit          stable;
      smp_t        s;
      real         h;
      real         m;
      logic [SZ:0] m0;
      logic [31:0] a0;
      lat     = 0;
      rdy_low = 1'b1;
      stable  = 1'b1;
      while (bus.out_valid !== 1'b1 && lat < 64) begin
         tick();
         lat++;
         if (bus.in_ready !== 1'b0) rdy_low = 1'b0;
      end
      chk_eq("latency", lat, ITER);
      chk_eq("in_ready_busy", rdy_low, 1);
      chk_eq("scoreboard_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
         s = sb.pop_front();
         if (s.x == 0 && s.y == 0) begin
            chk_eq("zero_mag", bus.mag, 0);
            chk_eq("zero_angle", bus.angle_out, 0);
         end else begin
            h = $sqrt(real'(s.x) * real'(s.x) + real'(s.y) * real'(s.y));
            m = K * h;
            // Integer truncation in each step adds a few LSBs of error beyond the angle bound.
            chk_tol("mag", bus.mag, longint'(m), longint'(0.001 * m) + 16, 1'b0);
            chk_tol("angle", bus.angle_out, exp_ang(s.x, s.y),
                    119305 + longint'(12.0 / m * CNT / TWO_PI), 1'b1);
         end
      end
      m0 = bus.mag;
      a0 = bus.angle_out;
      bus.out_ready = 1'b0;
      repeat (hold) begin
         tick();
         if (bus.mag !== m0 || bus.angle_out !== a0 || bus.out_valid !== 1'b1 ||
             bus.in_ready !== 1'b0) stable = 1'b0;
      end
      if (hold > 0) chk_eq("backpressure_hold", stable, 1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk_eq("out_valid_drop", bus.out_valid, 0);
      chk_eq("in_ready_rise", bus.in_ready, 1);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  prev;
      bit  stale;
      int  rx;
      int  ry;
      real rh;
      bus.in_valid  = 1'b0;
      bus.x_in      = '0;
      bus.y_in      = '0;
      bus.out_ready = 1'b0;
      repeat (3) tick();
      chk_eq("reset_in_ready", bus.in_ready, 1);
      chk_eq("reset_out_valid", bus.out_valid, 0);
      chk_eq("reset_mag", bus.mag, 0);
      chk_eq("reset_angle", bus.angle_out, 0);
      rst_n = 1'b1;
      tick();

      send(10000, 0, 1, 0);       result(0);
      send(0, 10000, 1, 0);       result(0);
      send(-10000, 0, 1, 0);      result(0);
      send(0, -10000, 1, 0);      result(0);
      send(10000, 10000, 1, 0);   result(0);
      send(-32768, -32768, 1, 0); result(0);
      send(32767, -1, 1, 0);      result(0);
      send(0, 0, 1, 0);           result(0);

      // in_valid held high with changing data while busy, then 20 cycles of backpressure
      send(1234, -5678, 1, 1);
      result(20);

      send(-7000, 3000, 1, 0);
      prev = last_acc;
      result(0);
      send(-200, -9000, 1, 0);
      chk_eq("issue_interval", last_acc - prev, ITER + 2);
      result(0);

      send(-12345, 2222, 0, 0);
      repeat (7) tick();
      rst_n = 1'b0;
      #1;
      chk_eq("midreset_in_ready", bus.in_ready, 1);
      chk_eq("midreset_out_valid", bus.out_valid, 0);
      chk_eq("midreset_mag", bus.mag, 0);
      chk_eq("midreset_angle", bus.angle_out, 0);
      tick();
      tick();
      rst_n = 1'b1;
      stale = 1'b0;
      repeat (24) begin
         tick();
         if (bus.out_valid !== 1'b0) stale = 1'b1;
      end
      chk_eq("no_stale_result", stale, 0);
      send(3000, 4000, 1, 0);
      result(0);

      repeat (1000) begin
         do begin
            rx = int'($urandom_range(0, 65535)) - 32768;
            ry = int'($urandom_range(0, 65535)) - 32768;
            rh = $sqrt(real'(rx) * real'(rx) + real'(ry) * real'(ry));
         end while (rh < 2048.0);
         send(rx, ry, 1, 0);
         result(0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
